mcs6530_bus_master: RTL
=======================

// Module: mcs6530_bus_master
// PURPOSE
//  Host-side bus-cycle sequencer that sits directly upstream of mcs6530 and drives its CPU bus.
//  Queues read/write requests from a testbench or soft host in a small FIFO.
//  Issues each request as a two-phi2 6502-style bus cycle (SETUP, ACCESS).
//  Captures read data and returns it on a valid/ready response channel.
// PARAMETERS
//  FIFO_DEPTH  4  request queue entries; power of two, >=2
//  CS1_ACTIVE  1  level driven on bus_cs1 while the chip is selected; inverse when idle
//  CS2_ACTIVE  0  level driven on bus_cs2 while the chip is selected; inverse when idle
// PORTS
//  phi2        in   1   system clock (6502 phase-2); all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid&req_ready at rising edge
//  req_we      in   1   1 = write, 0 = read
//  req_rs0     in   1   RS0 select (0 = ROM, 1 = RAM/IO/timer)
//  req_addr    in   10  A9..A0
//  req_wdata   in   8   write data; ignored for reads
//  rsp_valid   out  1   read response present
//  rsp_ready   in   1   response consumed when rsp_valid&rsp_ready
//  rsp_rdata   out  8   captured read data (8'hFF on error)
//  rsp_err     out  1   read sampled with bus_oe=0 (nothing drove the bus)
//  bus_addr    out  10  to mcs6530 A
//  bus_rs0     out  1   to mcs6530 RS0
//  bus_we_n    out  1   to mcs6530 we_n / R_W (1 = read)
//  bus_dout    out  8   to mcs6530 DI
//  bus_cs1     out  1   to CS1_PB6
//  bus_cs2     out  1   to CS2_PB5
//  bus_din     in   8   from mcs6530 DO
//  bus_oe      in   1   from mcs6530 OE
//  busy        out  1   1 when FIFO is non-empty or state != IDLE
// BEHAVIOUR
//  Reset (async, any state): FIFO emptied, state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, bus_addr=0, bus_rs0=0, bus_we_n=1, bus_dout=0, cs lines inactive, busy=0.
//   A request or response in flight at reset is discarded; nothing reappears after release.
//  FIFO: wr/rd pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
//   req_ready = !full and depends only on the registered count, not on a same-cycle pop.
//   A push into an empty FIFO is visible to the sequencer one cycle later.
//  FSM states: IDLE, SETUP, ACCESS, RESP.
//   IDLE: if FIFO non-empty, pop at the edge, load bus_* regs, go to SETUP.
//   SETUP: bus_addr/rs0/we_n/dout valid, cs active; go to ACCESS.
//   ACCESS: all bus_* held; at the closing edge:
//    read:  latch rsp_rdata=bus_oe?bus_din:8'hFF, rsp_err=!bus_oe; go to RESP.
//    write: if FIFO non-empty, pop and go to SETUP (back-to-back); else go to IDLE.
//  After ACCESS, bus_we_n returns to 1 and cs goes inactive unless SETUP follows immediately.
//  RESP: rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready.
//   On the handshake: pop and go to SETUP if FIFO non-empty, else IDLE. Bus is idle in RESP.
//  Latency: req handshake in cycle t gives SETUP in t+2, ACCESS in t+3, rsp_valid from t+4.
//   Write throughput is one transaction per 2 cycles; reads are limited by rsp_ready.
//  Requests are issued strictly in order; each read yields exactly one response; writes yield none.
//  bus_dout is driven only from write entries; it holds its last value during reads.
// TESTING
//  1 Reset, then write rs0=1 addr=10'h380 data=8'h5A -> SETUP t+2 and ACCESS t+3 show
//    bus_we_n=0, bus_addr=380, bus_dout=5A; no response is produced.
//  2 Read 10'h380 with DUT model returning 8'h5A and oe=1 -> rsp_valid at t+4, rdata=5A, err=0.
//  3 Read with bus_oe=0 -> rdata=8'hFF, err=1.
//  4 Push 5 writes while the sequencer is stalled behind a read held with rsp_ready=0 ->
//    req_ready=0 once 4 entries are queued; all 5 writes issue in order after release.
//  5 Back-to-back writes (6 queued) -> SETUP/ACCESS alternate with no IDLE gap; busy=0 after last.
//  6 Assert rst_n low during ACCESS of a read -> outputs take reset values immediately;
//    no rsp_valid after release.

Source files
------------

// File: rtl/mcs6530_bus_master.sv
// Host-side bus-cycle sequencer for the mcs6530: queues read/write requests and replays
// each one as a two-phase (SETUP, ACCESS) 6502-style bus cycle, returning read data.
module mcs6530_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter bit CS1_ACTIVE = 1'b1,
    parameter bit CS2_ACTIVE = 1'b0
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic       req_rs0,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] bus_addr,
    output logic       bus_rs0,
    output logic       bus_we_n,
    output logic [7:0] bus_dout,
    output logic       bus_cs1,
    output logic       bus_cs2,
    input  logic [7:0] bus_din,
    input  logic       bus_oe,
    output logic       busy
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic       we;
        logic       rs0;
        logic [9:0] addr;
        logic [7:0] wdata;
    } req_t;

    req_t        fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count;
    logic        fifo_empty, fifo_full, push, pop, bus_active;
    req_t        head;

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic        rs0_q, rs0_d;
    logic        txn_we_q, txn_we_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;

    // Occupancy comes from registered pointers only, so a pop in the same cycle never frees a slot early.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q[PW-1:0]];

    always_ff @(posedge phi2) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {req_we, req_rs0, req_addr, req_wdata};
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (!txn_we_q)        state_d = S_RESP;
                else if (!fifo_empty) state_d = S_SETUP;
                else                  state_d = S_IDLE;
            end
            S_RESP:   if (rsp_ready) state_d = fifo_empty ? S_IDLE : S_SETUP;
            default:  state_d = S_IDLE;
        endcase
    end

    // SETUP is only ever entered by taking the FIFO head, so entering it is the pop.
    always_comb begin
        pop        = (state_d == S_SETUP);
        bus_active = (state_q == S_SETUP) || (state_q == S_ACCESS);
        rsp_valid  = (state_q == S_RESP);
        busy       = !fifo_empty || (state_q != S_IDLE);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
        addr_d   = addr_q;
        rs0_d    = rs0_q;
        txn_we_d = txn_we_q;
        dout_d   = dout_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (pop) begin
            addr_d   = head.addr;
            rs0_d    = head.rs0;
            txn_we_d = head.we;
            if (head.we) dout_d = head.wdata;
        end
        if ((state_q == S_ACCESS) && !txn_we_q) begin
            rdata_d = bus_oe ? bus_din : 8'hFF;
            err_d   = !bus_oe;
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            rs0_q    <= 1'b0;
            txn_we_q <= 1'b0;
            dout_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            rs0_q    <= rs0_d;
            txn_we_q <= txn_we_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_rs0   = rs0_q;
    assign bus_dout  = dout_q;
    assign bus_we_n  = !(bus_active && txn_we_q);
    assign bus_cs1   = bus_active ? CS1_ACTIVE : !CS1_ACTIVE;
    assign bus_cs2   = bus_active ? CS2_ACTIVE : !CS2_ACTIVE;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
